token_stream_gather: RTL and testbench

- Receiving end of the token-serial handshake used between encoder-block sequencers and per-token compute units (MLP, projection heads).
- Accepts one EMB_DIM-wide token per transfer over a valid/ready channel and places it in a flattened SEQ_LEN*EMB_DIM buffer.
- Signals completion once SEQ_LEN tokens are collected.
- Downstream residual/layer-norm stages consume the gathered buffer.

---
 rtl/token_stream_gather.sv | 104 ++++++++++
 tb/tb_token_stream_gather.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/token_stream_gather.sv
// Token-serial gather: collects SEQ_LEN tokens of EMB_DIM elements into a flat buffer.
// Optional macro TOKEN_IDX_CHECK_EN: drop tokens whose tok_idx disagrees with the slot count.
module token_stream_gather #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LEN    = 16,
  parameter int EMB_DIM    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          tok_valid,
  output logic                          tok_ready,
  input  logic [DATA_WIDTH-1:0]         tok_data [EMB_DIM],
  input  logic [31:0]                   tok_idx,
  input  logic                          tok_last,
  output logic [DATA_WIDTH-1:0]         out_block [SEQ_LEN*EMB_DIM],
  output logic                          out_valid,
  output logic                          done,
  output logic [$clog2(SEQ_LEN+1)-1:0]  tok_count,
  output logic                          err_seq
);

  localparam int CW = $clog2(SEQ_LEN + 1);
  localparam int NE = SEQ_LEN * EMB_DIM;
  localparam int AW = (NE > 1) ? $clog2(NE) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]            state_reg, state_next;
  logic [CW-1:0]         count_reg;
  logic                  err_reg;
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] block_reg [NE];

  logic          xfer, idx_ok, wr_en, is_final, last_err;
  logic [AW-1:0] wr_base;

  assign xfer     = tok_valid && (state_reg == S_COLLECT);
  assign is_final = (count_reg == CW'(SEQ_LEN - 1));
  assign last_err = xfer && (tok_last != is_final);
  assign wr_base  = AW'(count_reg) * AW'(EMB_DIM);

`ifdef TOKEN_IDX_CHECK_EN
  assign idx_ok = (tok_idx == 32'(count_reg));
`else
  // Placement is by arrival order; the index is deliberately not looked at.
  logic unused_idx;
  assign unused_idx = ^tok_idx;
  assign idx_ok     = 1'b1;
`endif

  // A mismatched index still completes the handshake but leaves the buffer untouched.
  assign wr_en = xfer && idx_ok;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start) state_next = S_COLLECT;
      S_COLLECT: if (wr_en && is_final) state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      count_reg     <= '0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      for (int i = 0; i < NE; i++) block_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && start) begin
        count_reg     <= '0;
        err_reg       <= 1'b0;
        out_valid_reg <= 1'b0;
      end
      // Count only advances while collecting, so it naturally stops at SEQ_LEN.
      if (wr_en) begin
        count_reg <= count_reg + 1'b1;
        for (int e = 0; e < EMB_DIM; e++) block_reg[wr_base + AW'(e)] <= tok_data[e];
      end
      if (last_err || (xfer && !idx_ok)) err_reg <= 1'b1;
      if (wr_en && is_final) out_valid_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NE; gi++) begin : g_out
      assign out_block[gi] = block_reg[gi];
    end
  endgenerate

  assign tok_ready = (state_reg == S_COLLECT);
  assign done      = (state_reg == S_DONE);
  assign tok_count = count_reg;
  assign err_seq   = err_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_token_stream_gather.sv
// Directed + randomized bench for token_stream_gather against a transaction-level gather model.
module tb_token_stream_gather;
  localparam int DW = 16;
  localparam int SL = 4;
  localparam int ED = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic tok_valid = 1'b0;
  logic tok_last = 1'b0;
  logic [31:0] tok_idx = '0;
  logic [DW-1:0] tok_data [ED];
  logic tok_ready, out_valid, done, err_seq;
  logic [DW-1:0] out_block [SL*ED];
  logic [$clog2(SL+1)-1:0] tok_count;

  always #5 clk = ~clk;

  token_stream_gather #(.DATA_WIDTH(DW), .SEQ_LEN(SL), .EMB_DIM(ED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_data(tok_data), .tok_idx(tok_idx), .tok_last(tok_last), .out_block(out_block),
    .out_valid(out_valid), .done(done), .tok_count(tok_count), .err_seq(err_seq)
  );

  // Reference: "armed" gather collecting tokens, plus a pending completion pulse.
  bit m_busy, m_fin, m_err, m_ov;
  int m_cnt;
  logic [DW-1:0] m_buf [SL*ED];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("tok_ready", 32'(tok_ready), 32'(m_busy));
    chk("done", 32'(done), 32'(m_fin));
    chk("tok_count", 32'(tok_count), 32'(m_cnt));
    chk("err_seq", 32'(err_seq), 32'(m_err));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    for (int i = 0; i < SL*ED; i++) chk($sformatf("buf[%0d]", i), 32'(out_block[i]), 32'(m_buf[i]));
  endtask

  task automatic model_clear();
    m_busy = 0; m_fin = 0; m_err = 0; m_ov = 0; m_cnt = 0;
    for (int i = 0; i < SL*ED; i++) m_buf[i] = '0;
  endtask

  task automatic step(bit s, bit v, logic [DW-1:0] d0, logic [DW-1:0] d1, int idx, bit last);
    bit ok;
    start = s; tok_valid = v; tok_data[0] = d0; tok_data[1] = d1;
    tok_idx = 32'(idx); tok_last = last;
    if (m_fin) m_fin = 0;
    else if (!m_busy) begin
      if (s) begin m_busy = 1; m_cnt = 0; m_err = 0; m_ov = 0; end
    end else if (v) begin
      ok = 1;
      if (last != (m_cnt == SL-1)) m_err = 1;
`ifdef TOKEN_IDX_CHECK_EN
      ok = (idx == m_cnt);
`endif
      if (!ok) m_err = 1;
      else begin
        m_buf[m_cnt*ED] = d0;
        m_buf[m_cnt*ED+1] = d1;
        m_cnt++;
        if (m_cnt == SL) begin m_busy = 0; m_fin = 1; m_ov = 1; end
      end
    end
    @(posedge clk); #1;
    start = 0; tok_valid = 0; tok_last = 0;
    check_all();
  endtask

  // Correctly indexed token with random payload, tok_last on the final slot.
  task automatic tok(bit v);
    step(0, v, DW'($urandom), DW'($urandom), m_cnt, m_cnt == SL-1);
  endtask

  task automatic do_reset();
    start = 0; tok_valid = 0; tok_last = 0;
    rst_n = 0;
    #2;
    model_clear();
    check_all();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    tok_data[0] = '0; tok_data[1] = '0;
    #1;
    do_reset();

    // Token offered while idle must not be taken.
    step(0, 1, 16'hAAAA, 16'hBBBB, 0, 0);
    step(0, 1, 16'hCCCC, 16'hDDDD, 0, 1);

    // Basic back-to-back gather.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 2, 0, 0);
    step(0, 1, 3, 4, 1, 0);
    step(0, 1, 5, 6, 2, 0);
    step(0, 1, 7, 8, 3, 1);
    chk("basic_done_pulse", 32'(done), 32'd1);
    for (int i = 0; i < SL*ED; i++) chk($sformatf("basic_buf[%0d]", i), 32'(out_block[i]), 32'(i + 1));
    // Producer keeps pushing after completion.
    tok(1); tok(1);

    // Gapped stream with backpressure-style idle cycles.
    step(1, 0, 0, 0, 0, 0);
    tok(1); tok(0); tok(0); tok(1); tok(1); tok(0); tok(1);
    tok(1); tok(1);

    // tok_last on the second token.
    step(1, 0, 0, 0, 0, 0);
    tok(1);
    step(0, 1, DW'($urandom), DW'($urandom), m_cnt, 1);
    chk("early_last_err", 32'(err_seq), 32'd1);
    tok(1); tok(1); tok(0);
    // tok_last missing on the final token.
    step(1, 0, 0, 0, 0, 0);
    chk("restart_err_clr", 32'(err_seq), 32'd0);
    chk("restart_ov_clr", 32'(out_valid), 32'd0);
    tok(1); tok(1); tok(1);
    step(0, 1, DW'($urandom), DW'($urandom), m_cnt, 0);
    tok(0);

    // start while collecting is ignored.
    step(1, 0, 0, 0, 0, 0);
    tok(1); tok(1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, DW'($urandom), DW'($urandom), m_cnt, 0);
    tok(1); step(1, 0, 0, 0, 0, 0); tok(0);

    // Reset with a partial gather, then a clean gather.
    step(1, 0, 0, 0, 0, 0);
    tok(1); tok(1);
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    tok(1); tok(1); tok(1); tok(1); tok(0);

    // Out-of-order index sequence 0,2,1,2,3.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 16'h100, 16'h101, 0, 0);
    step(0, 1, 16'h200, 16'h201, 2, 0);
    step(0, 1, 16'h110, 16'h111, 1, 0);
    step(0, 1, 16'h120, 16'h121, 2, 0);
    step(0, 1, 16'h130, 16'h131, 3, 1);
    tok(0); tok(0);

    // Randomized traffic, including protocol errors and occasional resets.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(99) == 0) do_reset();
      else step($urandom_range(7) == 0, $urandom_range(1) == 1, DW'($urandom), DW'($urandom),
                ($urandom_range(5) == 0) ? int'($urandom_range(SL-1)) : m_cnt,
                (m_cnt == SL-1) ^ ($urandom_range(9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
